// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and register-file types.
//   REG_ADDR_W / REG_DATA_W : default register address and data widths
//   REG_ZERO                : index of the architectural zero register
//   reg_addr_t / data_t     : register address and data word types
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] data_t;

endpackage : cpu_pkg

// File: rtl/sb_popcount.sv
// Combinational population count of a flag vector.
//   vec : input flags, W bits
//   cnt : number of set bits in vec, CNT_W bits (CNT_W >= clog2(W+1))
module sb_popcount #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic [W-1:0]     vec,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
    end

endmodule : sb_popcount

// File: rtl/regfile_sb.sv
// Multi-entry register file with a per-register pending-write scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ra1/ra2 -> rd1/rd2  : combinational read ports (optional write bypass)
//   busy1/busy2         : pending-write flag of the addressed entries
//   RegWrite, wa, wd    : clocked writeback port; also clears the busy flag
//   issue_en, issue_rd  : reserve a destination register (sets busy)
//   issue_stall         : reservation refused, destination already pending
//   pend_cnt            : registered count of busy entries
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_stall,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned NREG  = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam bit          HAS_ZERO   = (ZERO_REG != 0);
    localparam bit          HAS_BYPASS = (BYPASS != 0);

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   wclr;
    logic [NREG-1:0]   eff_busy;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   busy_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              wr_ok;

    // Writes to the hardwired zero register are dropped.
    assign wr_ok = RegWrite && !(HAS_ZERO && (wa == '0));

    // Scoreboard next state: a writeback clears its entry, an accepted issue sets it.
    always_comb begin
        wclr        = '0;
        set_vec     = '0;
        if (RegWrite) begin
            wclr[wa] = 1'b1;
        end
        eff_busy    = busy & ~wclr;
        issue_stall = issue_en && eff_busy[issue_rd];
        if (issue_en && !issue_stall && !(HAS_ZERO && (issue_rd == '0))) begin
            set_vec[issue_rd] = 1'b1;
        end
        busy_next   = (busy & ~wclr) | set_vec;
    end

    // Read port 1: zero register, then same-cycle bypass, then array.
    always_comb begin
        rd1   = mem[ra1];
        busy1 = HAS_BYPASS ? eff_busy[ra1] : busy[ra1];
        if (HAS_BYPASS && RegWrite && (wa == ra1)) begin
            rd1 = wd;
        end
        if (HAS_ZERO && (ra1 == '0)) begin
            rd1   = '0;
            busy1 = 1'b0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2   = mem[ra2];
        busy2 = HAS_BYPASS ? eff_busy[ra2] : busy[ra2];
        if (HAS_BYPASS && RegWrite && (wa == ra2)) begin
            rd2 = wd;
        end
        if (HAS_ZERO && (ra2 == '0)) begin
            rd2   = '0;
            busy2 = 1'b0;
        end
    end

    sb_popcount #(
        .W     (NREG),
        .CNT_W (CNT_W)
    ) u_popcount (
        .vec (busy_next),
        .cnt (cnt_next)
    );

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    // Busy flags and their count update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= cnt_next;
        end
    end

endmodule : regfile_sb
